// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants, key-schedule state encoding, GF(2^8)
//               xtime and the forward S-box lookup.
// Revision    : 1.0
// ============================================================================
package aes_pkg;

  localparam int AES128_NR       = 10;
  localparam int AES128_NK_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_t;

  // Byte 0x00 sits in the most significant byte of the table.
  localparam logic [2047:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] aes_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] aes_sbox(input logic [7:0] x);
    return c_sbox[{~x, 3'b000} +: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_key_expand_128.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_expand_128
// Description : One combinational AES-128 key-expansion step (round key in,
//               next round key out) for a given round constant.
// Revision    : 1.0
// ============================================================================
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic [127:0] i_key,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_key
);

  logic [31:0] w_w0, w_w1, w_w2, w_w3;
  logic [31:0] w_rot, w_sub, w_temp;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;

  assign {w_w0, w_w1, w_w2, w_w3} = i_key;

  assign w_rot  = {w_w3[23:0], w_w3[31:24]};
  assign w_sub  = {aes_sbox(w_rot[31:24]), aes_sbox(w_rot[23:16]),
                   aes_sbox(w_rot[15:8]),  aes_sbox(w_rot[7:0])};
  assign w_temp = w_sub ^ {i_rcon, 24'h000000};

  assign w_n0 = w_w0 ^ w_temp;
  assign w_n1 = w_w1 ^ w_n0;
  assign w_n2 = w_w2 ^ w_n1;
  assign w_n3 = w_w3 ^ w_n2;

  assign o_key = {w_n0, w_n1, w_n2, w_n3};

endmodule
`default_nettype wire

// File: rtl/aes_key_schedule_128.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_schedule_128
// Description : Iterative AES-128 round-key generator; one expansion step per
//               clock into an 11-entry key store read by index.
// Revision    : 1.0
// ============================================================================
module aes_key_schedule_128
  import aes_pkg::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_valid,
  input  logic [3:0]   rk_idx,
  output logic [127:0] rk_out
);

  localparam logic [3:0] c_last_rnd = 4'(AES128_NR);

  ks_state_t    state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] cur_q, cur_d;
  logic         keys_valid_q, keys_valid_d;

  logic         w_wr_en;
  logic [3:0]   w_wr_idx;
  logic [127:0] w_wr_data;
  logic [127:0] w_next_key;
  logic [127:0] w_rd_data;

  logic [127:0] rk_mem [0:AES128_NR];

  aes_key_expand_128 u_expand (
    .i_key  (cur_q),
    .i_rcon (rcon_q),
    .o_key  (w_next_key)
  );

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    rcon_d       = rcon_q;
    cur_d        = cur_q;
    keys_valid_d = keys_valid_q;
    w_wr_en      = 1'b0;
    w_wr_idx     = 4'd0;
    w_wr_data    = w_next_key;
    case (state_q)
      IDLE, DONE: begin
        if (key_valid) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = 4'd0;
          w_wr_data    = key_in;
          cur_d        = key_in;
          rnd_d        = 4'd1;
          rcon_d       = 8'h01;
          keys_valid_d = 1'b0;
          state_d      = EXPAND;
        end
      end
      EXPAND: begin
        w_wr_en  = 1'b1;
        w_wr_idx = rnd_q;
        cur_d    = w_next_key;
        rcon_d   = aes_xtime(rcon_q);
        // rnd saturates at the last round instead of wrapping.
        if (rnd_q == c_last_rnd) begin
          state_d      = DONE;
          keys_valid_d = 1'b1;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rnd_q        <= 4'd0;
      rcon_q       <= 8'h01;
      cur_q        <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rnd_q        <= rnd_d;
      rcon_q       <= rcon_d;
      cur_q        <= cur_d;
      keys_valid_q <= keys_valid_d;
    end
  end

  // Key store has no reset; its contents are only meaningful once keys_valid is set.
  always_ff @(posedge clk) begin
    if (!rst && w_wr_en) begin
      for (int i = 0; i <= AES128_NR; i++) begin
        if (w_wr_idx == 4'(i)) rk_mem[i] <= w_wr_data;
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i <= AES128_NR; i++) begin
      if (rk_idx == 4'(i)) w_rd_data = rk_mem[i];
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      logic [127:0] rk_out_q;
      always_ff @(posedge clk) begin
        if (rst) rk_out_q <= '0;
        else     rk_out_q <= w_rd_data;
      end
      assign rk_out = rk_out_q;
    end else begin : g_comb_out
      assign rk_out = w_rd_data;
    end
  endgenerate

  assign key_ready  = (state_q != EXPAND);
  assign busy       = (state_q == EXPAND);
  assign keys_valid = keys_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_key_schedule_128.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_key_schedule_128
// Description : Scoreboard bench for aes_key_schedule_128 (combinational and
//               registered read-port builds driven in parallel).
// Revision    : 1.0
// ============================================================================
module tb_aes_key_schedule_128;

  localparam logic [127:0] K_FIPS    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_SEQ     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic [3:0]   rk_idx;
  logic         key_ready, busy, keys_valid;
  logic [127:0] rk_out;
  logic         key_ready_r, busy_r, keys_valid_r;
  logic [127:0] rk_out_r;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] val;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  aes_key_schedule_128 #(.REG_OUT(1'b0)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .busy(busy), .keys_valid(keys_valid),
    .rk_idx(rk_idx), .rk_out(rk_out)
  );

  aes_key_schedule_128 #(.REG_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready_r), .busy(busy_r), .keys_valid(keys_valid_r),
    .rk_idx(rk_idx), .rk_out(rk_out_r)
  );

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [3:0] idx, input logic [127:0] val);
    exp_t e;
    e.idx = idx;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic push_key_refs(input logic [127:0] key);
    push_exp(4'd0, key);
    if (key == K_FIPS) begin
      push_exp(4'd1, FIPS_RK1);
      push_exp(4'd10, FIPS_RK10);
    end else begin
      push_exp(4'd10, SEQ_RK10);
      for (int i = 11; i <= 15; i++) push_exp(4'(i), 128'h0);
    end
  endtask

  task automatic drain;
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rk_idx = e.idx;
      #1;
      check_val($sformatf("rk%0d", e.idx), rk_out, e.val);
      tick;
    end
  endtask

  task automatic send_key(input logic [127:0] key);
    check_val("ready_before_accept", 128'(key_ready), 128'd1);
    key_in    = key;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    while (keys_valid !== 1'b1 && n < 40) begin
      tick;
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    logic [3:0]   lag_idx [4];
    logic [127:0] lag_val [4];
    logic [127:0] prev;

    rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_idx = 4'd0;
    tick; tick;
    check_val("rst_key_ready", 128'(key_ready), 128'd1);
    check_val("rst_busy", 128'(busy), 128'd0);
    check_val("rst_keys_valid", 128'(keys_valid), 128'd0);
    check_val("rst_rk_out_reg", rk_out_r, 128'h0);
    rst = 1'b0;
    tick;

    // FIPS-197 vector
    push_key_refs(K_FIPS);
    send_key(K_FIPS);
    check_val("fips_busy", 128'(busy), 128'd1);
    check_val("fips_kv_low", 128'(keys_valid), 128'd0);
    wait_kv(n);
    check_val("fips_kv_latency", 128'(n), 128'd10);
    check_val("fips_busy_done", 128'(busy), 128'd0);
    drain;

    // Back-to-back accept in DONE with a same-cycle read of rk[0]
    push_key_refs(K_SEQ);
    rk_idx = 4'd0; key_in = K_SEQ; key_valid = 1'b1;
    #1;
    check_val("b2b_old_rk0", rk_out, K_FIPS);
    tick;
    key_valid = 1'b0;
    check_val("b2b_kv_fall", 128'(keys_valid), 128'd0);
    check_val("b2b_new_rk0", rk_out, K_SEQ);
    wait_kv(n);
    check_val("b2b_kv_latency", 128'(n), 128'd10);
    drain;

    // Second key held on key_valid throughout expansion
    key_in = K_FIPS; key_valid = 1'b1;
    tick;
    key_in = K_SEQ;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (key_ready === 1'b0) cnt++;
      tick;
    end
    check_val("hold_ready_low_cycles", 128'(cnt), 128'd10);
    check_val("hold_ready_done", 128'(key_ready), 128'd1);
    check_val("hold_kv_done", 128'(keys_valid), 128'd1);
    rk_idx = 4'd10;
    #1;
    check_val("hold_first_rk10", rk_out, FIPS_RK10);
    push_key_refs(K_SEQ);
    tick;
    key_valid = 1'b0;
    wait_kv(n);
    check_val("hold_kv_latency", 128'(n), 128'd10);
    drain;

    // Reset four cycles into an expansion
    send_key(K_FIPS);
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_val("abort_keys_valid", 128'(keys_valid), 128'd0);
    check_val("abort_key_ready", 128'(key_ready), 128'd1);
    check_val("abort_busy", 128'(busy), 128'd0);
    check_val("abort_rk_out_reg", rk_out_r, 128'h0);
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick;
      if (keys_valid !== 1'b0) cnt++;
    end
    check_val("abort_kv_stays_low", 128'(cnt), 128'd0);
    push_key_refs(K_FIPS);
    send_key(K_FIPS);
    wait_kv(n);
    check_val("abort_kv_latency", 128'(n), 128'd10);
    drain;

    // Registered read port lags rk_idx by one cycle; last drained index was 10
    lag_idx[0] = 4'd0;  lag_val[0] = K_FIPS;
    lag_idx[1] = 4'd10; lag_val[1] = FIPS_RK10;
    lag_idx[2] = 4'd1;  lag_val[2] = FIPS_RK1;
    lag_idx[3] = 4'd12; lag_val[3] = 128'h0;
    prev = FIPS_RK10;
    for (int i = 0; i < 4; i++) begin
      rk_idx = lag_idx[i];
      #1;
      check_val($sformatf("lag_hold%0d", i), rk_out_r, prev);
      check_val($sformatf("lag_comb%0d", i), rk_out, lag_val[i]);
      tick;
      check_val($sformatf("lag_new%0d", i), rk_out_r, lag_val[i]);
      prev = lag_val[i];
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
